// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-loads a program image over valid/ready, then runs the fetch loop.
// Optional issued-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BOOT_ADDR = 32'h0,
    parameter logic [31:0] HALT_INSN = 32'h00000063
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       issue_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              hs;
    logic [31:0]       pc_next;
    logic              pc_bad;
    logic              is_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= BOOT_ADDR;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Range check happens before pc could ever wrap, so plain 32-bit add is enough.
    assign pc_next = br_taken ? br_target : pc_q + 32'd4;
    assign pc_bad  = (pc_next[1:0] != 2'b00) || (|pc_next[31:ADDR_W+2]);
    assign is_halt = (imem_rdata == HALT_INSN);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_cnt_d = load_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (load_last) begin
                        load_cnt_d = '0;
                    end else begin
                        load_cnt_d = ADDR_W'(1);
                        state_d    = S_LOAD;
                    end
                end else if (start) begin
                    state_d = S_RUN;
                    pc_d    = BOOT_ADDR;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (load_last) begin
                        load_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else if (&load_cnt_q) begin
                        state_d = S_FAULT;
                    end else begin
                        load_cnt_d = load_cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (instr_valid) begin
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else if (pc_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = BOOT_ADDR;
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_d    = S_RUN;
                    pc_d       = BOOT_ADDR;
                    load_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready  = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD: load_ready = 1'b1;
            S_RUN:          instr_valid = ~stall;
            S_HALT:         halted = 1'b1;
            S_FAULT:        fault = 1'b1;
            default:        ;
        endcase
        hs         = load_valid & load_ready;
        imem_we    = hs;
        imem_wdata = load_data;
        imem_addr  = hs ? load_cnt_q : pc_q[ADDR_W+1:2];
    end

    assign pc    = pc_q;
    assign instr = imem_rdata;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic        start_go;

    // A start that actually launches RUN restarts the count; a load in IDLE outranks start.
    assign start_go = start && (((state_q == S_IDLE) && !hs) ||
                                (state_q == S_HALT) || (state_q == S_FAULT));

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (start_go) begin
            issue_cnt_d = '0;
        end else if (instr_valid && (issue_cnt_q != 32'hFFFF_FFFF)) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
`else
    assign issue_cnt = 32'h0;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer that owns the 32-bit word-addressed instruction memory port. Two jobs:
- Boot-loads a program image through a valid/ready stream.
- Runs the fetch loop: drives PC, presents the instruction to the core, applies branch redirects and stalls.

It detects the self-branch halt idiom (beq x0,x0,0) and out-of-range PCs, so the testbench and top level get clean halted/fault status.

Parameters:
ADDR_W, 6, instruction memory word-address width (depth = 2**ADDR_W words)
BOOT_ADDR, 32'h0, byte PC loaded on start
HALT_INSN, 32'h00000063, encoding treated as halt (beq x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  loader word valid
load_ready  out  1  controller accepts loader word
load_data  in  32  program word
load_last  in  1  final word of image (qualified by handshake)
start  in  1  begin/restart execution (level, sampled per cycle)
stall  in  1  core stall; hold PC, suppress issue
br_taken  in  1  redirect for current issued instruction
br_target  in  32  byte redirect target
imem_addr  out  ADDR_W  memory word address
imem_we  out  1  memory write enable
imem_wdata  out  32  memory write data
imem_rdata  in  32  memory read data (combinational read)
pc  out  32  current byte PC
instr  out  32  instruction to core (= imem_rdata)
instr_valid  out  1  instr issued this cycle
halted  out  1  HALT state
fault  out  1  FAULT state
issue_cnt  out  32  issued-instruction counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=BOOT_ADDR, load_cnt=0, issue_cnt=0. Combinational outputs in IDLE are instr_valid=0, halted=0, fault=0, load_ready=1.
- States: IDLE, LOAD, RUN, HALT, FAULT.
- Load handshake: hs = load_valid & load_ready. imem_we = hs (combinational), imem_wdata = load_data, imem_addr = load_cnt. load_ready=1 only in IDLE/LOAD.
- IDLE:
  - hs: word written at addr 0; load_cnt<=1; next state LOAD, or stay IDLE (load_cnt<=0) if load_last.
  - else start: RUN, pc<=BOOT_ADDR.
  - hs has priority over start.
- LOAD:
  - hs writes at load_cnt.
  - load_last → IDLE, load_cnt<=0.
  - hs at load_cnt=2**ADDR_W-1 without load_last: word is written, then FAULT (image overflow).
  - start ignored.
- RUN:
  - imem_addr = pc[ADDR_W+1:2], imem_we=0, instr_valid = ~stall.
  - Zero-latency fetch: instr valid the same cycle pc is presented.
  - On edge with instr_valid=1:
    - instr==HALT_INSN → HALT, pc holds; br_taken ignored.
    - else br_taken → pc<=br_target.
    - else pc<=pc+4.
  - New pc misaligned (bits[1:0]!=0) or ≥ 4·2**ADDR_W → FAULT, pc holds old value. This covers falling off the end.
  - stall=1: pc holds, br_taken ignored.
- HALT: instr_valid=0, halted=1. start → RUN, pc<=BOOT_ADDR.
- FAULT: instr_valid=0, fault=1, load_ready=0. start → RUN, pc<=BOOT_ADDR, load_cnt<=0.
- Outside RUN, when not loading, imem_addr = pc word index.
- Reset mid-load or mid-run: immediate return to reset values. Memory contents are not cleared.
- pc arithmetic: 32-bit, no wrap needed because the range check precedes any wrap.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: issue_cnt increments by 1 on every edge with instr_valid=1 (including the halt instruction). It saturates at 32'hFFFFFFFF and clears on reset or on start from IDLE/HALT/FAULT.
- Undefined: issue_cnt tied to 32'h0, no counter flops.

Test Plan:
- Load 4 words (0x00500093, 0x00108113, 0x00000013, 0x00000063) with load_last on the 4th, then pulse start → words at addrs 0..3; pc goes 0,4,8,12; instr_valid for 4 cycles; halted=1 with pc=12; issue_cnt=4 when enabled.
- In RUN at pc=8, br_taken=1, br_target=0x20 → next pc=0x20. br_target=0x22 → fault=1, pc stays 8.
- stall=1 for 3 cycles at pc=4 → pc=4 held, instr_valid=0, br_taken pulses ignored. Release → pc=8 next cycle.
- Run off the end (ADDR_W=6, pc=0xFC, non-branch instr) → FAULT, pc=0xFC. Then start → RUN at pc=0, fault=0.
- Stream 64 words without load_last → all written, then fault=1 and load_ready=0.
- Assert rst_n=0 mid-LOAD at load_cnt=5 → same-cycle return to IDLE, load_ready=1, pc=0. The next load starts at addr 0.
